// File: rtl/uart_ring_buffer_if.sv
// -----------------------------------------------------------------------------
// uart_ring_buffer_if
// Bundles the handshake, data and debug signals of uart_ring_buffer.
//   master : the client (UART logic / core / testbench). It drives the write
//            and read requests and receives the read data, the ack and the debug words.
//   slave  : the ring buffer itself.
// Signals:
//   writeEnable  write request, sampled on the rising clock edge
//   data[7:0]    byte to write, sampled with writeEnable
//   readEnable   read request, sampled on the rising clock edge
//   dataReadAck  one-cycle strobe for each successful read
//   dataRead     byte returned by the most recent successful read
//   debug        {8'h00, count, rdPtr, wrPtr} state snapshot
//   debug2       {dropped writes, failed reads}, or zero without statistics
// -----------------------------------------------------------------------------
interface uart_ring_buffer_if;
  logic        writeEnable;
  logic [7:0]  data;
  logic        readEnable;
  logic        dataReadAck;
  logic [7:0]  dataRead;
  logic [31:0] debug;
  logic [31:0] debug2;

  modport master (
    output writeEnable, data, readEnable,
    input  dataReadAck, dataRead, debug, debug2
  );

  modport slave (
    input  writeEnable, data, readEnable,
    output dataReadAck, dataRead, debug, debug2
  );
endinterface

// File: rtl/uart_ring_buffer.sv
// -----------------------------------------------------------------------------
// uart_ring_buffer
// This is a circular FIFO of 8-bit bytes. It sits between the UART receive and
// transmit logic and the consuming core. It has 2^BITLENGTH slots. One slot is
// always left empty, so the buffer holds at most 2^BITLENGTH-1 bytes.
// A write to a full buffer is dropped. A read from an empty buffer is dropped.
// Read data and its one-cycle acknowledge appear in the cycle after the request.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    uart_ring_buffer_if.slave (handshakes, data, debug words)
//
// Optional build macro: UART_RING_BUFFER_STATS_EN
//   When defined, debug2 = {16-bit saturating dropped-write count,
//   16-bit saturating failed-read count}. Reset clears both counts.
//   When undefined, debug2 is constant zero and the counter logic is not built.
// -----------------------------------------------------------------------------
module uart_ring_buffer #(
  parameter int BITLENGTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  uart_ring_buffer_if.slave bus
);

  localparam int DEPTH = 1 << BITLENGTH;

  logic [BITLENGTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [BITLENGTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [BITLENGTH-1:0] wr_inc_s, rd_inc_s;
  logic [7:0]           count_q, count_d;
  logic                 ack_q, ack_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic [7:0]           mem_q [DEPTH];

  logic empty_s, full_s, wr_ok_s, rd_ok_s;

  // Flags and success decisions, all taken from pre-edge state
  always_comb begin
    wr_inc_s = wr_ptr_q + BITLENGTH'(1);
    rd_inc_s = rd_ptr_q + BITLENGTH'(1);
    empty_s  = (wr_ptr_q == rd_ptr_q);
    full_s   = (wr_inc_s == rd_ptr_q);
    // Each side is decided on its own. There is no same-cycle bypass, so a read
    // of an empty buffer fails even when a write arrives on the same edge.
    wr_ok_s  = bus.writeEnable && !full_s;
    rd_ok_s  = bus.readEnable  && !empty_s;
  end

  // Next-state values for the pointers, the count and the read port
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ack_d     = 1'b0;
    rd_data_d = rd_data_q;

    if (wr_ok_s) begin
      wr_ptr_d = wr_inc_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_ok_s) begin
      rd_ptr_d  = rd_inc_s;
      ack_d     = 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d  = rd_ptr_q;
      ack_d     = 1'b0;
      rd_data_d = rd_data_q;
    end

    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + 8'd1;
      2'b01:   count_d = count_q - 8'd1;
      default: count_d = count_q;
    endcase
  end

  // Control registers. Reset takes priority over any read or write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 8'd0;
      ack_q     <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array. Reset does not clear it; the pointer reset is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !reset) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  assign bus.dataReadAck = ack_q;
  assign bus.dataRead    = rd_data_q;
  assign bus.debug       = {8'h00, count_q, 8'(rd_ptr_q), 8'(wr_ptr_q)};

`ifdef UART_RING_BUFFER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;

  // Saturating counts of dropped writes and failed reads
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (bus.writeEnable && full_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    if (bus.readEnable && empty_s && (fail_cnt_q != 16'hFFFF)) begin
      fail_cnt_d = fail_cnt_q + 16'd1;
    end else begin
      fail_cnt_d = fail_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.debug2 = {drop_cnt_q, fail_cnt_q};
`else
  assign bus.debug2 = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_uart_ring_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_ring_buffer
// Self-checking bench for uart_ring_buffer with BITLENGTH=2 (capacity 3).
// A reference queue holds the bytes that should be in the buffer. When a read is
// expected to succeed, its byte moves to a queue of expected read results. That
// entry is popped and compared when dataReadAck shows the read.
// -----------------------------------------------------------------------------
module tb_uart_ring_buffer;

  localparam int BL    = 2;
  localparam int DEPTH = 4;
  localparam int CAP   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  uart_ring_buffer_if bus_if ();

  uart_ring_buffer #(.BITLENGTH(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb_q[$];
  logic [7:0] exp_rd_q[$];
  int         wr_m = 0;
  int         rd_m = 0;
  int         drop_m = 0;
  int         fail_m = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_dbg;
    logic [31:0] exp_dbg2;
    exp_dbg = {8'h00, 8'(sb_q.size()), 8'(rd_m), 8'(wr_m)};
    check_val({tag, "_debug"}, bus_if.debug, exp_dbg);
`ifdef UART_RING_BUFFER_STATS_EN
    exp_dbg2 = {16'(drop_m), 16'(fail_m)};
`else
    exp_dbg2 = 32'h0;
`endif
    check_val({tag, "_debug2"}, bus_if.debug2, exp_dbg2);
  endtask

  // One clock cycle: drive at negedge, update the model, check after posedge
  task automatic do_cycle(input logic we, input logic [7:0] wd, input logic re);
    logic       rd_ok;
    logic       wr_ok;
    logic [7:0] exp_b;
    @(negedge clk);
    bus_if.writeEnable = we;
    bus_if.data        = wd;
    bus_if.readEnable  = re;
    rd_ok = re && (sb_q.size() != 0);
    wr_ok = we && (sb_q.size() != CAP);
    if (we && !wr_ok && drop_m < 65535) drop_m++;
    if (re && !rd_ok && fail_m < 65535) fail_m++;
    if (rd_ok) begin
      exp_rd_q.push_back(sb_q.pop_front());
      rd_m = (rd_m + 1) % DEPTH;
    end
    if (wr_ok) begin
      sb_q.push_back(wd);
      wr_m = (wr_m + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    check_val("ack", {31'd0, bus_if.dataReadAck}, {31'd0, rd_ok});
    if (rd_ok) begin
      exp_b = exp_rd_q.pop_front();
      check_val("rd_data", {24'd0, bus_if.dataRead}, {24'd0, exp_b});
      last_rd = exp_b;
    end else begin
      check_val("rd_hold", {24'd0, bus_if.dataRead}, {24'd0, last_rd});
    end
    check_state("cyc");
  endtask

  // Reset for one edge while a read and a write are also requested
  task automatic do_reset();
    @(negedge clk);
    reset              = 1'b1;
    bus_if.writeEnable = 1'b1;
    bus_if.readEnable  = 1'b1;
    bus_if.data        = 8'hAA;
    @(posedge clk);
    #1;
    sb_q.delete();
    exp_rd_q.delete();
    wr_m = 0; rd_m = 0; drop_m = 0; fail_m = 0;
    last_rd = 8'h00;
    check_val("rst_ack", {31'd0, bus_if.dataReadAck}, 32'd0);
    check_val("rst_data", {24'd0, bus_if.dataRead}, 32'd0);
    check_state("rst");
    @(negedge clk);
    reset              = 1'b0;
    bus_if.writeEnable = 1'b0;
    bus_if.readEnable  = 1'b0;
  endtask

  initial begin
    bus_if.writeEnable = 1'b0;
    bus_if.readEnable  = 1'b0;
    bus_if.data        = 8'h00;

    do_reset();
    do_cycle(1'b0, 8'h00, 1'b0);
    check_val("idle_debug", bus_if.debug, 32'h0000_0000);

    // Fill to capacity. The fourth write is dropped.
    do_cycle(1'b1, 8'h02, 1'b0);
    do_cycle(1'b1, 8'h03, 1'b0);
    do_cycle(1'b1, 8'h04, 1'b0);
    check_val("full_debug", bus_if.debug, 32'h0003_0003);
    do_cycle(1'b1, 8'h05, 1'b0);
    check_val("drop_debug", bus_if.debug, 32'h0003_0003);

    // Two reads, each acknowledged in the following cycle
    do_cycle(1'b0, 8'h00, 1'b1);
    check_val("plan_rd0", {24'd0, bus_if.dataRead}, 32'h02);
    do_cycle(1'b0, 8'h00, 1'b1);
    check_val("plan_rd1", {24'd0, bus_if.dataRead}, 32'h03);
    do_cycle(1'b0, 8'h00, 1'b0);

    // The write pointer wraps. The third write is dropped. The buffer then drains in order.
    do_cycle(1'b1, 8'h07, 1'b0);
    do_cycle(1'b1, 8'h08, 1'b0);
    do_cycle(1'b1, 8'h09, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1);
    do_cycle(1'b0, 8'h00, 1'b1);
    do_cycle(1'b0, 8'h00, 1'b1);
    check_val("plan_rd_wrap", {24'd0, bus_if.dataRead}, 32'h08);

    // Read on empty: no ack, and the data holds
    do_cycle(1'b0, 8'h00, 1'b1);
    check_val("empty_hold", {24'd0, bus_if.dataRead}, 32'h08);

    // Read and write together with one byte stored
    do_cycle(1'b1, 8'h11, 1'b0);
    do_cycle(1'b1, 8'h22, 1'b1);
    check_val("both_rd", {24'd0, bus_if.dataRead}, 32'h11);

    // Read and write together when full: the read succeeds and the write is dropped
    do_cycle(1'b1, 8'h33, 1'b0);
    do_cycle(1'b1, 8'h44, 1'b0);
    do_cycle(1'b1, 8'h55, 1'b1);

    // Reset partway through, then read with no ack
    do_reset();
    do_cycle(1'b1, 8'h66, 1'b1);
    do_cycle(1'b1, 8'h77, 1'b0);
    do_reset();
    do_cycle(1'b0, 8'h00, 1'b1);
    check_val("post_rst_ack", {31'd0, bus_if.dataReadAck}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    do_cycle(1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
